fcvt_f2i: RTL and testbench

FCVT_F2I -- requirements
Module: fcvt_f2i

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fround_incr.sv | 24 ++
 rtl/fcvt_f2i.sv | 220 ++++++++++++++++++++++
 tb/tb_fcvt_f2i.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode and operand-class enums plus rm decoding.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fpu_rm_e;

  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,
    CLS_SUBNORM = 3'd1,
    CLS_NORMAL  = 3'd2,
    CLS_INF     = 3'd3,
    CLS_NAN     = 3'd4
  } fpu_class_e;

  // Reserved encodings 5-7 fall back to round-to-nearest-even.
  function automatic fpu_rm_e decode_rm(input logic [2:0] rm_raw);
    fpu_rm_e rm;
    case (rm_raw)
      3'd1:    rm = RM_RTZ;
      3'd2:    rm = RM_RDN;
      3'd3:    rm = RM_RUP;
      3'd4:    rm = RM_RMM;
      default: rm = RM_RNE;
    endcase
    return rm;
  endfunction

endpackage

// File: rtl/fround_incr.sv
// Rounding increment decision from rounding mode, sign, lsb, guard and sticky bits.
module fround_incr
  import fpu_pkg::*;
(
  input  fpu_rm_e rm,
  input  logic    sign,
  input  logic    lsb,
  input  logic    guard,
  input  logic    sticky,
  output logic    increment
);

  always_comb begin
    increment = 1'b0;
    case (rm)
      RM_RTZ:  increment = 1'b0;
      RM_RDN:  increment = sign & (guard | sticky);
      RM_RUP:  increment = ~sign & (guard | sticky);
      RM_RMM:  increment = guard;
      default: increment = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/fcvt_f2i.sv
// Float-to-integer converter, 2-stage valid/ready pipeline with saturation and flags.
// Optional sticky flag accumulator enabled by FCVT_F2I_STICKY_FLAGS_EN.
module fcvt_f2i
  import fpu_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int FRACTION_WIDTH   = 23,
  parameter int INT_WIDTH        = 32,
  parameter int BIASING_CONSTANT = 2 ** (EXPONENT_WIDTH - 1) - 1
) (
  input  logic                      fpu_clk,
  input  logic                      fpu_rst,
`ifdef FCVT_F2I_STICKY_FLAGS_EN
  input  logic                      fcvt_flags_clr_i,
  output logic [1:0]                fcvt_flags_sticky_o,
`endif
  input  logic                      fcvt_valid_i,
  output logic                      fcvt_ready_o,
  input  logic                      fcvt_sign_i,
  input  logic [EXPONENT_WIDTH-1:0] fcvt_exp_i,
  input  logic [FRACTION_WIDTH-1:0] fcvt_frac_i,
  input  logic [2:0]                fcvt_rm_i,
  input  logic                      fcvt_unsigned_i,
  output logic                      fcvt_valid_o,
  input  logic                      fcvt_ready_i,
  output logic [INT_WIDTH-1:0]      fcvt_int_o,
  output logic                      fcvt_invalid_o,
  output logic                      fcvt_inexact_o,
  output logic                      fcvt_zero_o
);

  localparam int EW  = EXPONENT_WIDTH;
  localparam int FW  = FRACTION_WIDTH;
  localparam int IW  = INT_WIDTH;
  localparam int SHW = $clog2(IW + 1);
  localparam int XW  = (EW + 2 > 8) ? EW + 2 : 8;
  localparam int WW  = FW + 1 + IW;

  localparam logic signed [XW-1:0] UNB_MAX   = XW'(IW);
  localparam logic        [IW+1:0] SMAX_MAG  = {3'b000, {(IW-1){1'b1}}};
  localparam logic        [IW+1:0] SMIN_MAG  = {3'b001, {(IW-1){1'b0}}};
  localparam logic        [IW+1:0] UMAX_MAG  = {2'b00, {IW{1'b1}}};
  localparam logic        [IW-1:0] INT_SMAX  = {1'b0, {(IW-1){1'b1}}};
  localparam logic        [IW-1:0] INT_SMIN  = {1'b1, {(IW-1){1'b0}}};

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             unsgn;
    fpu_rm_e          rm;
    fpu_class_e       cls;
    logic             huge;
    logic [FW:0]      mant;
    logic [SHW-1:0]   sh;
    logic             tguard;
    logic             tsticky;
  } s1_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] val;
    logic          invalid;
    logic          inexact;
    logic          zero;
  } res_t;

  s1_t  s1_d,  s1_q;
  res_t res_d, res_q;

  logic                 advance;
  logic signed [XW-1:0] exp_unb;
  logic                 exp_zero;
  logic                 exp_ones;
  logic                 frac_nz;

  assign advance  = fcvt_ready_o;
  assign exp_zero = (fcvt_exp_i == '0);
  assign exp_ones = &fcvt_exp_i;
  assign frac_nz  = |fcvt_frac_i;
  assign exp_unb  = $signed(XW'({2'b00, fcvt_exp_i})) - $signed(XW'(BIASING_CONSTANT));

  // Stage 1: classify and reduce the operand to mantissa + left-shift amount.
  // Magnitudes below 1 bypass the shifter via precomputed guard/sticky.
  always_comb begin
    s1_d = s1_q;
    if (advance) begin
      s1_d       = '0;
      s1_d.valid = fcvt_valid_i;
      s1_d.sign  = fcvt_sign_i;
      s1_d.unsgn = fcvt_unsigned_i;
      s1_d.rm    = decode_rm(fcvt_rm_i);
      if (exp_zero) begin
        s1_d.cls     = frac_nz ? CLS_SUBNORM : CLS_ZERO;
        s1_d.tsticky = frac_nz;
      end else if (exp_ones) begin
        s1_d.cls  = frac_nz ? CLS_NAN : CLS_INF;
        s1_d.huge = ~frac_nz;
      end else begin
        s1_d.cls = CLS_NORMAL;
        if (exp_unb[XW-1]) begin
          s1_d.tguard  = (exp_unb == '1);
          s1_d.tsticky = (exp_unb != '1) | frac_nz;
        end else if (exp_unb > UNB_MAX) begin
          s1_d.huge = 1'b1;
        end else begin
          s1_d.mant = {1'b1, fcvt_frac_i};
          s1_d.sh   = exp_unb[SHW-1:0];
        end
      end
    end
  end

  // Stage 2: shift, round, saturate.
  logic [WW-1:0]  wide;
  logic [IW:0]    int_mag;
  logic           guard;
  logic           sticky;
  logic           incr;
  logic [IW+1:0]  rnd_mag;
  logic [IW-1:0]  mag_lo;

  always_comb begin
    wide    = {{IW{1'b0}}, s1_q.mant} << s1_q.sh;
    int_mag = wide[WW-1:FW];
    guard   = wide[FW-1] | s1_q.tguard;
    sticky  = (|wide[FW-2:0]) | s1_q.tsticky;
  end

  fround_incr u_round (
    .rm        (s1_q.rm),
    .sign      (s1_q.sign),
    .lsb       (int_mag[0]),
    .guard     (guard),
    .sticky    (sticky),
    .increment (incr)
  );

  assign rnd_mag = {1'b0, int_mag} + {{(IW+1){1'b0}}, incr};
  assign mag_lo  = rnd_mag[IW-1:0];

  always_comb begin
    res_d = res_q;
    if (advance) begin
      res_d = '0;
      if (s1_q.valid) begin
        res_d.valid = 1'b1;
        if (s1_q.cls == CLS_NAN) begin
          res_d.invalid = 1'b1;
          res_d.val     = s1_q.unsgn ? '1 : INT_SMAX;
        end else if (s1_q.huge) begin
          res_d.invalid = 1'b1;
          if (s1_q.sign) res_d.val = s1_q.unsgn ? '0 : INT_SMIN;
          else           res_d.val = s1_q.unsgn ? '1 : INT_SMAX;
        end else if (s1_q.unsgn) begin
          if (!s1_q.sign) begin
            if (rnd_mag > UMAX_MAG) begin
              res_d.invalid = 1'b1;
              res_d.val     = '1;
            end else begin
              res_d.val = mag_lo;
            end
          end else if (rnd_mag != '0) begin
            res_d.invalid = 1'b1;
          end
        end else if (!s1_q.sign) begin
          if (rnd_mag > SMAX_MAG) begin
            res_d.invalid = 1'b1;
            res_d.val     = INT_SMAX;
          end else begin
            res_d.val = mag_lo;
          end
        end else begin
          if (rnd_mag > SMIN_MAG) begin
            res_d.invalid = 1'b1;
            res_d.val     = INT_SMIN;
          end else begin
            res_d.val = -mag_lo;
          end
        end
        res_d.inexact = ~res_d.invalid & (guard | sticky);
        res_d.zero    = (res_d.val == '0);
      end
    end
  end

  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      s1_q  <= '0;
      res_q <= '0;
    end else begin
      s1_q  <= s1_d;
      res_q <= res_d;
    end
  end

`ifdef FCVT_F2I_STICKY_FLAGS_EN
  logic [1:0] sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (fcvt_flags_clr_i) sticky_d = '0;
    if (res_q.valid && fcvt_ready_i) sticky_d = sticky_d | {res_q.invalid, res_q.inexact};
  end

  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) sticky_q <= '0;
    else         sticky_q <= sticky_d;
  end

  assign fcvt_flags_sticky_o = sticky_q;
`endif

  assign fcvt_ready_o   = ~res_q.valid | fcvt_ready_i;
  assign fcvt_valid_o   = res_q.valid;
  assign fcvt_int_o     = res_q.val;
  assign fcvt_invalid_o = res_q.invalid;
  assign fcvt_inexact_o = res_q.inexact;
  assign fcvt_zero_o    = res_q.zero;

endmodule

// File: tb/tb_fcvt_f2i.sv
// Self-checking bench for fcvt_f2i (binary32 -> int32) with an arithmetic reference model.
module tb_fcvt_f2i;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, sign_i, uns_i, valid_o, ready_i;
  logic [7:0]  exp_i;
  logic [22:0] frac_i;
  logic [2:0]  rm_i;
  logic [31:0] int_o;
  logic        inv_o, inx_o, zero_o;
`ifdef FCVT_F2I_STICKY_FLAGS_EN
  logic        clr_i;
  logic [1:0]  sticky_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fcvt_f2i #(
    .EXPONENT_WIDTH (8),
    .FRACTION_WIDTH (23),
    .INT_WIDTH      (32)
  ) dut (
    .fpu_clk             (clk),
    .fpu_rst             (rst),
`ifdef FCVT_F2I_STICKY_FLAGS_EN
    .fcvt_flags_clr_i    (clr_i),
    .fcvt_flags_sticky_o (sticky_o),
`endif
    .fcvt_valid_i        (valid_i),
    .fcvt_ready_o        (ready_o),
    .fcvt_sign_i         (sign_i),
    .fcvt_exp_i          (exp_i),
    .fcvt_frac_i         (frac_i),
    .fcvt_rm_i           (rm_i),
    .fcvt_unsigned_i     (uns_i),
    .fcvt_valid_o        (valid_o),
    .fcvt_ready_i        (ready_i),
    .fcvt_int_o          (int_o),
    .fcvt_invalid_o      (inv_o),
    .fcvt_inexact_o      (inx_o),
    .fcvt_zero_o         (zero_o)
  );

  typedef struct packed {
    logic [31:0] val;
    logic        inv;
    logic        inx;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [31:0] f;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] val;
    logic        inv;
    logic        inx;
    logic        zr;
  } vec_t;

  // Value = 1.frac * 2^(e-127); integer part and discarded remainder compared against one half.
  function automatic exp_t ref_model(input logic [31:0] f, input logic [2:0] rm, input logic uns);
    exp_t   r;
    int     e, u, k, cmp;
    longint m, ip, rem, half, v;
    logic   neg, nan, inf_like, up;
    e = int'(f[30:23]);
    neg = f[31];
    nan = 1'b0; inf_like = 1'b0; ip = 0; rem = 0; cmp = -1; up = 1'b0;
    if (e == 255) begin
      if (f[22:0] != 0) nan = 1'b1; else inf_like = 1'b1;
    end else if (e == 0) begin
      rem = longint'(f[22:0]);
    end else begin
      m = longint'({1'b1, f[22:0]});
      u = e - 127;
      if (u >= 40) inf_like = 1'b1;
      else if (u >= 23) ip = m << (u - 23);
      else begin
        k = 23 - u;
        if (k > 40) rem = m;
        else begin
          ip   = m >> k;
          rem  = m & ((64'sd1 << k) - 1);
          half = 64'sd1 << (k - 1);
          cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
        end
      end
    end
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = neg && (rem != 0);
      3'd3:    up = !neg && (rem != 0);
      3'd4:    up = (cmp >= 0);
      default: up = (cmp > 0) || (cmp == 0 && ip[0]);
    endcase
    v = ip + longint'(up);
    if (inf_like) v = 64'sd1 << 50;
    if (neg) v = -v;
    r = '0;
    if (nan) begin
      r.inv = 1'b1;
      r.val = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (uns) begin
      if (v < 0) r.inv = 1'b1;
      else if (v > 64'sd4294967295) begin r.inv = 1'b1; r.val = 32'hFFFF_FFFF; end
      else r.val = v[31:0];
    end else begin
      if (v > 64'sd2147483647) begin r.inv = 1'b1; r.val = 32'h7FFF_FFFF; end
      else if (v < -64'sd2147483648) begin r.inv = 1'b1; r.val = 32'h8000_0000; end
      else r.val = v[31:0];
    end
    r.inx  = !r.inv && (rem != 0);
    r.zero = (r.val == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    int sel;
    f   = $urandom;
    sel = $urandom_range(0, 19);
    if (sel == 0)      f[30:23] = 8'h00;
    else if (sel == 1) f[30:23] = 8'hFF;
    else if (sel == 2) begin f[30:23] = 8'($urandom_range(120, 160)); f[22:0] = '0; end
    else               f[30:23] = 8'($urandom_range(110, 162));
    return f;
  endfunction

  task automatic drive_op(input logic [31:0] f, input logic [2:0] rm, input logic uns);
    sign_i = f[31];
    exp_i  = f[30:23];
    frac_i = f[22:0];
    rm_i   = rm;
    uns_i  = uns;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({valid_o, ready_o, int_o, inv_o, inx_o, zero_o} !== {1'b0, 1'b1, 32'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: got v=%b r=%b int=%h flags=%b%b%b, expected v=0 r=1 int=0 flags=000",
               valid_o, ready_o, int_o, inv_o, inx_o, zero_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({valid_o, ready_o} !== 2'b01) begin
      fails++;
      $display("FAIL reset_release: got v=%b r=%b, expected v=0 r=1", valid_o, ready_o);
    end
  endtask

  task automatic test_directed();
    vec_t vecs [20];
    vecs = '{
      '{32'h40200000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0},
      '{32'h40200000, 3'd4, 1'b0, 32'h00000003, 1'b0, 1'b1, 1'b0},
      '{32'h40200000, 3'd3, 1'b0, 32'h00000003, 1'b0, 1'b1, 1'b0},
      '{32'h40200000, 3'd1, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0},
      '{32'h40200000, 3'd5, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0},
      '{32'hC0200000, 3'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0},
      '{32'hC0200000, 3'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0},
      '{32'hC0200000, 3'd1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'h4F32D05E, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
      '{32'h4F32D05E, 3'd0, 1'b1, 32'hB2D05E00, 1'b0, 1'b0, 1'b0},
      '{32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
      '{32'hBE99999A, 3'd0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1},
      '{32'h00000001, 3'd3, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0},
      '{32'h00000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1},
      '{32'hFF800000, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0},
      '{32'h3F000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1},
      '{32'h3FC00000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0},
      '{32'h4F000000, 3'd1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
      '{32'hCF000000, 3'd1, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0},
      '{32'h7F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_op(vecs[i].f, vecs[i].rm, vecs[i].uns);
      valid_i = 1'b1;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL latency_early[%0d]: got valid_o=%b one cycle after accept, expected 0", i, valid_o);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({valid_o, int_o, inv_o, inx_o, zero_o} !==
          {1'b1, vecs[i].val, vecs[i].inv, vecs[i].inx, vecs[i].zr}) begin
        fails++;
        $display("FAIL directed[%0d] op=%h rm=%0d uns=%b: got v=%b int=%h inv/inx/zero=%b%b%b, expected v=1 int=%h inv/inx/zero=%b%b%b",
                 i, vecs[i].f, vecs[i].rm, vecs[i].uns, valid_o, int_o, inv_o, inx_o, zero_o,
                 vecs[i].val, vecs[i].inv, vecs[i].inx, vecs[i].zr);
      end
    end
    @(negedge clk);
  endtask

`ifdef FCVT_F2I_STICKY_FLAGS_EN
  task automatic test_sticky();
    @(negedge clk);
    tests++;
    if (sticky_o !== 2'b11) begin
      fails++;
      $display("FAIL sticky_accum: got %b, expected 11", sticky_o);
    end
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    tests++;
    if (sticky_o !== 2'b00) begin
      fails++;
      $display("FAIL sticky_clear: got %b, expected 00", sticky_o);
    end
    drive_op(32'h40200000, 3'd0, 1'b0);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    tests++;
    if (sticky_o !== 2'b01) begin
      fails++;
      $display("FAIL sticky_set_wins: got %b, expected 01", sticky_o);
    end
    drive_op(32'h7FC00000, 3'd0, 1'b0);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (sticky_o !== 2'b11) begin
      fails++;
      $display("FAIL sticky_or: got %b, expected 11", sticky_o);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] ops [4];
    logic [2:0]  rms [4];
    logic        unss [4];
    exp_t        q[$];
    exp_t        e;
    logic [35:0] held_v;
    logic        held;
    int          sent, got;
    ops  = '{32'h40200000, 32'hC0200000, 32'h4F32D05E, 32'h3FC00000};
    rms  = '{3'd0, 3'd2, 3'd0, 3'd0};
    unss = '{1'b0, 1'b0, 1'b1, 1'b0};
    sent = 0; got = 0; held = 1'b0; held_v = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (held) begin
        tests++;
        if ({valid_o, int_o, inv_o, inx_o, zero_o} !== held_v) begin
          fails++;
          $display("FAIL b2b_stall_stable cyc=%0d: got %h, expected held %h", c,
                   {valid_o, int_o, inv_o, inx_o, zero_o}, held_v);
        end
      end
      ready_i = !(c >= 3 && c <= 5);
      if (sent < 4) begin
        drive_op(ops[sent], rms[sent], unss[sent]);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      tests++;
      if (ready_o !== (!valid_o || ready_i)) begin
        fails++;
        $display("FAIL b2b_ready cyc=%0d: got %b, expected %b", c, ready_o, (!valid_o || ready_i));
      end
      if (valid_o && ready_i) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected cyc=%0d: got result %h, expected none", c, int_o);
        end else begin
          e = q.pop_front();
          if ({int_o, inv_o, inx_o, zero_o} !== e) begin
            fails++;
            $display("FAIL b2b_result[%0d]: got int=%h flags=%b%b%b, expected int=%h flags=%b%b%b",
                     got, int_o, inv_o, inx_o, zero_o, e.val, e.inv, e.inx, e.zero);
          end
        end
        got++;
      end
      held   = valid_o && !ready_i;
      held_v = {valid_o, int_o, inv_o, inx_o, zero_o};
      if (valid_i && ready_o) begin
        q.push_back(ref_model(ops[sent], rms[sent], unss[sent]));
        sent++;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tests++;
    if (got != 4 || sent != 4) begin
      fails++;
      $display("FAIL b2b_count: got sent=%0d received=%0d, expected 4 and 4", sent, got);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e, cur;
    logic [31:0] f;
    logic [2:0]  rm;
    logic        uns;
    logic [35:0] held_v;
    logic        held;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; held = 1'b0; held_v = '0; cur = '0;
    while ((sent < 400 || q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        tests++;
        if ({valid_o, int_o, inv_o, inx_o, zero_o} !== held_v) begin
          fails++;
          $display("FAIL rand_stall_stable cyc=%0d: got %h, expected held %h", cyc,
                   {valid_o, int_o, inv_o, inx_o, zero_o}, held_v);
        end
      end
      ready_i = ($urandom_range(0, 99) >= 30);
      if (sent < 400 && $urandom_range(0, 99) < 80) begin
        f   = rand_float();
        rm  = 3'($urandom_range(0, 7));
        uns = 1'($urandom_range(0, 1));
        drive_op(f, rm, uns);
        cur = ref_model(f, rm, uns);
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_o && ready_i) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_unexpected cyc=%0d: got result %h, expected none", cyc, int_o);
        end else begin
          e = q.pop_front();
          if ({int_o, inv_o, inx_o, zero_o} !== e) begin
            fails++;
            $display("FAIL rand_result[%0d]: got int=%h flags=%b%b%b, expected int=%h flags=%b%b%b",
                     got, int_o, inv_o, inx_o, zero_o, e.val, e.inv, e.inx, e.zero);
          end
        end
        got++;
      end
      held   = valid_o && !ready_i;
      held_v = {valid_o, int_o, inv_o, inx_o, zero_o};
      if (valid_i && ready_o) begin
        q.push_back(cur);
        sent++;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tests++;
    if (cyc >= 5000 || got != 400) begin
      fails++;
      $display("FAIL rand_drain: got received=%0d after %0d cycles, expected 400 within 5000", got, cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    ready_i = 1'b0;
    drive_op(32'h40200000, 3'd0, 1'b0);
    valid_i = 1'b1;
    @(negedge clk);
    drive_op(32'h3FC00000, 3'd0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    tests++;
    if (valid_o !== 1'b1) begin
      fails++;
      $display("FAIL inflight_setup: got valid_o=%b, expected 1", valid_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({valid_o, ready_o, int_o, inv_o, inx_o, zero_o} !== {1'b0, 1'b1, 32'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_async: got v=%b r=%b int=%h flags=%b%b%b, expected v=0 r=1 int=0 flags=000",
               valid_o, ready_o, int_o, inv_o, inx_o, zero_o);
    end
`ifdef FCVT_F2I_STICKY_FLAGS_EN
    tests++;
    if (sticky_o !== 2'b00) begin
      fails++;
      $display("FAIL reset_sticky: got %b, expected 00", sticky_o);
    end
`endif
    @(posedge clk);
    #1;
    tests++;
    if ({valid_o, ready_o} !== 2'b01) begin
      fails++;
      $display("FAIL reset_hold: got v=%b r=%b, expected v=0 r=1", valid_o, ready_o);
    end
    @(negedge clk);
    rst     = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if (valid_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_stale cyc=%0d: got valid_o=%b int=%h, expected valid_o=0", c, valid_o, int_o);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    drive_op(32'd0, 3'd0, 1'b0);
`ifdef FCVT_F2I_STICKY_FLAGS_EN
    clr_i = 1'b0;
`endif
    test_reset();
    test_directed();
`ifdef FCVT_F2I_STICKY_FLAGS_EN
    test_sticky();
`endif
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
